// File: rtl/cart_bs_pkg.sv
// cart_bs_pkg: scheme codes, size constants, signature table and decision helpers for cart_bs_detect
package cart_bs_pkg;

    // bankswitch scheme codes as consumed by force_bs of A2601top
    localparam logic [3:0] BS_NONE = 4'd0;
    localparam logic [3:0] BS_F8   = 4'd1;
    localparam logic [3:0] BS_F6   = 4'd2;
    localparam logic [3:0] BS_FE   = 4'd3;
    localparam logic [3:0] BS_E0   = 4'd4;
    localparam logic [3:0] BS_3F   = 4'd5;
    localparam logic [3:0] BS_F4   = 4'd6;
    localparam logic [3:0] BS_P2   = 4'd7;
    localparam logic [3:0] BS_FA   = 4'd8;
    localparam logic [3:0] BS_CV   = 4'd9;
    localparam logic [3:0] BS_UA   = 4'd11;
    localparam logic [3:0] BS_E7   = 4'd12;

    localparam int MAX_SIZE_DEF = 32768;
    localparam int HIT_SAT_DEF  = 7;

    // ROM image sizes the decision keys on
    localparam logic [16:0] SZ_4K  = 17'd4096;
    localparam logic [16:0] SZ_8K  = 17'd8192;
    localparam logic [16:0] SZ_10K = 17'd10240;
    localparam logic [16:0] SZ_12K = 17'd12288;
    localparam logic [16:0] SZ_16K = 17'd16384;
    localparam logic [16:0] SZ_32K = 17'd32768;
    localparam logic [16:0] SZ_SAT = 17'h1FFFF;

    // opcode signatures, oldest byte in the top byte, newest byte in the bottom byte
    localparam logic [23:0] SIG_E0_A = 24'h8DE01F;
    localparam logic [23:0] SIG_E0_B = 24'hADE9FF;
    localparam logic [23:0] SIG_E7_A = 24'hADE2FF;
    localparam logic [23:0] SIG_E7_B = 24'hADE5FF;
    localparam logic [23:0] SIG_UA   = 24'h8D4002;
    localparam logic [23:0] SIG_CV   = 24'h9DFFF3;
    localparam logic [23:0] SIG_FE   = 24'hD0C6C5;
    localparam logic [23:0] SIG_3F   = 24'h00853F;

    // one saturating hit count per signature family
    typedef struct packed {
        logic [2:0] e0;
        logic [2:0] e7;
        logic [2:0] ua;
        logic [2:0] cv;
        logic [2:0] fe;
        logic [2:0] f3;
    } hits_t;

    // first matching rule wins: extension, then size plus signature evidence, then plain size
    function automatic logic [3:0] pick_scheme(input logic [3:0] ext, input logic [16:0] size, input hits_t h);
        if (ext != BS_NONE) return ext;
        if (size == SZ_10K) return BS_P2;
        if (size > SZ_4K && h.f3 >= 3'd2) return BS_3F;
        if (size == SZ_8K && h.e0 != 3'd0) return BS_E0;
        if (size == SZ_16K && h.e7 != 3'd0) return BS_E7;
        if (size == SZ_8K && h.ua != 3'd0) return BS_UA;
        if (size <= SZ_4K && h.cv != 3'd0) return BS_CV;
        if (size == SZ_8K && h.fe != 3'd0) return BS_FE;
        if (size == SZ_8K) return BS_F8;
        if (size == SZ_12K) return BS_FA;
        if (size == SZ_16K) return BS_F6;
        if (size == SZ_32K) return BS_F4;
        return BS_NONE;
    endfunction

    // mode 1 forces off, modes 2 and 3 force on, mode 0 follows auto detection
    function automatic logic pick_sc(input logic [1:0] mode, input logic auto_sc);
        return mode[1] | (~mode[0] & auto_sc);
    endfunction

endpackage

// File: rtl/cart_bs_detect_if.sv
// cart_bs_detect_if: HPS ROM download byte stream as seen by the loader-side detector
interface cart_bs_detect_if;
    logic        dl_active;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;

    modport master (output dl_active, dl_wr, dl_addr, dl_data);
    modport slave  (input  dl_active, dl_wr, dl_addr, dl_data);
endinterface

// File: rtl/cart_bs_sig_match.sv
// cart_bs_sig_match: compares the download window with one or two byte patterns and counts hits, saturating
module cart_bs_sig_match #(
    parameter int          LEN   = 3,
    parameter logic [23:0] PAT_A = 24'h0,
    parameter logic [23:0] PAT_B = 24'h0,
    parameter bit          ALT   = 1'b0,
    parameter logic [2:0]  SAT   = 3'd7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        en,
    input  logic [23:0] win,
    output logic [2:0]  hits
);
    // two-byte patterns ignore the oldest window byte
    localparam logic [23:0] MASK = (LEN == 2) ? 24'h00FFFF : 24'hFFFFFF;

    logic hit;

    assign hit = ((win & MASK) == (PAT_A & MASK)) | (ALT & ((win & MASK) == (PAT_B & MASK)));

    // count every qualified match until saturation; clr restarts the count for a new download
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hits <= 3'd0;
        else if (clr) hits <= 3'd0;
        else if (en && hit && hits != SAT) hits <= hits + 3'd1;
    end
endmodule

// File: rtl/cart_bs_detect.sv
// cart_bs_detect: watches the ROM download stream and decides bankswitch scheme and SuperChip flag
// Optional: define CART_BS_SC_DETECT_EN to build SuperChip auto detection (bank-prefix comparator)
module cart_bs_detect import cart_bs_pkg::*; #(
    parameter int MAX_SIZE = MAX_SIZE_DEF,
    parameter int HIT_SAT  = HIT_SAT_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    cart_bs_detect_if.slave        dl,
    input  logic [3:0]             ext_bs,
    input  logic [1:0]             sc_mode,
    output logic [3:0]             bs,
    output logic                   sc,
    output logic [16:0]            rom_size,
    output logic                   valid,
    output logic                   busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SCAN   = 2'd1;
    localparam logic [1:0] DECIDE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [24:0] SCAN_LIMIT = 25'(MAX_SIZE);
    localparam logic [2:0]  SAT        = 3'(HIT_SAT);

    logic [1:0]  state;
    logic        act_q;
    logic        rise;
    logic        fall;
    logic        clr;
    logic        scan_wr;
    logic        in_range;
    logic        match_en;
    logic        sc_auto;
    logic [23:0] win;
    logic [23:0] win_next;
    logic [1:0]  fill;
    logic [16:0] size;
    logic [16:0] size_next;
    logic [2:0]  h_e0;
    logic [2:0]  h_e7;
    logic [2:0]  h_ua;
    logic [2:0]  h_cv;
    logic [2:0]  h_fe;
    logic [2:0]  h_f3;
    hits_t       hits;

    assign rise      = dl.dl_active & ~act_q;
    assign fall      = ~dl.dl_active & act_q;
    assign clr       = rise & (state != SCAN);
    assign scan_wr   = (state == SCAN) & dl.dl_wr;
    assign in_range  = dl.dl_addr < SCAN_LIMIT;
    assign win_next  = {win[15:0], dl.dl_data};
    assign size_next = (dl.dl_addr >= 25'h1FFFF) ? SZ_SAT : dl.dl_addr[16:0] + 17'd1;
    // a match only counts once the window holds three real bytes of this download
    assign match_en  = scan_wr & in_range & (fill == 2'd2);
    assign hits      = {h_e0, h_e7, h_ua, h_cv, h_fe, h_f3};

    // act_q resets high so a download already in progress at reset release is never mistaken for a new one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            act_q    <= 1'b1;
            busy     <= 1'b0;
            valid    <= 1'b0;
            bs       <= BS_NONE;
            sc       <= 1'b0;
            rom_size <= 17'd0;
        end else begin
            act_q <= dl.dl_active;
            if (clr) begin
                state <= SCAN;
                busy  <= 1'b1;
                valid <= 1'b0;
            end else if (state == SCAN && fall) begin
                state <= DECIDE;
            end else if (state == DECIDE) begin
                state    <= DONE;
                busy     <= 1'b0;
                valid    <= 1'b1;
                bs       <= pick_scheme(ext_bs, size, hits);
                sc       <= pick_sc(sc_mode, sc_auto);
                rom_size <= size;
            end
        end
    end

    // byte window and size counter; bytes past the scan limit only advance the size
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win  <= 24'd0;
            fill <= 2'd0;
            size <= 17'd0;
        end else if (clr) begin
            win  <= 24'd0;
            fill <= 2'd0;
            size <= 17'd0;
        end else if (scan_wr) begin
            size <= size_next;
            if (in_range) begin
                win  <= win_next;
                fill <= (fill == 2'd2) ? 2'd2 : fill + 2'd1;
            end
        end
    end

    cart_bs_sig_match #(.LEN(3), .PAT_A(SIG_E0_A), .PAT_B(SIG_E0_B), .ALT(1'b1), .SAT(SAT)) u_e0 (
        .clk(clk), .reset_n(reset_n), .clr(clr), .en(match_en), .win(win_next), .hits(h_e0)
    );
    cart_bs_sig_match #(.LEN(3), .PAT_A(SIG_E7_A), .PAT_B(SIG_E7_B), .ALT(1'b1), .SAT(SAT)) u_e7 (
        .clk(clk), .reset_n(reset_n), .clr(clr), .en(match_en), .win(win_next), .hits(h_e7)
    );
    cart_bs_sig_match #(.LEN(3), .PAT_A(SIG_UA), .ALT(1'b0), .SAT(SAT)) u_ua (
        .clk(clk), .reset_n(reset_n), .clr(clr), .en(match_en), .win(win_next), .hits(h_ua)
    );
    cart_bs_sig_match #(.LEN(3), .PAT_A(SIG_CV), .ALT(1'b0), .SAT(SAT)) u_cv (
        .clk(clk), .reset_n(reset_n), .clr(clr), .en(match_en), .win(win_next), .hits(h_cv)
    );
    cart_bs_sig_match #(.LEN(3), .PAT_A(SIG_FE), .ALT(1'b0), .SAT(SAT)) u_fe (
        .clk(clk), .reset_n(reset_n), .clr(clr), .en(match_en), .win(win_next), .hits(h_fe)
    );
    cart_bs_sig_match #(.LEN(2), .PAT_A(SIG_3F), .ALT(1'b0), .SAT(SAT)) u_3f (
        .clk(clk), .reset_n(reset_n), .clr(clr), .en(match_en), .win(win_next), .hits(h_f3)
    );

`ifdef CART_BS_SC_DETECT_EN
    logic [7:0] byte0;
    logic       mism;

    // remember byte 0 and set a sticky flag when any of the first 128 bytes of a 4K bank differs from it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte0 <= 8'd0;
            mism  <= 1'b0;
        end else if (clr) begin
            mism <= 1'b0;
        end else if (scan_wr && in_range) begin
            if (dl.dl_addr == 25'd0) byte0 <= dl.dl_data;
            else if (dl.dl_addr[11:7] == 5'd0 && dl.dl_data != byte0) mism <= 1'b1;
        end
    end

    assign sc_auto = (size >= SZ_8K) & ~mism;
`else
    assign sc_auto = 1'b0;
`endif

endmodule

// File: tb/tb_cart_bs_detect.sv
// tb_cart_bs_detect: randomized scoreboard bench for cart_bs_detect; define CART_BS_SC_DETECT_EN to expect SuperChip auto detection
module tb_cart_bs_detect;
    localparam int MAX = 32768;

    typedef struct {
        logic [3:0]  bs;
        logic        sc;
        logic [16:0] size;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  ext_bs = 4'd0;
    logic [1:0]  sc_mode = 2'd0;
    logic [3:0]  bs;
    logic        sc;
    logic [16:0] rom_size;
    logic        valid;
    logic        busy;
    exp_t        exp_q[$];
    logic [7:0]  img[];
    int          errors = 0;
    int          checks = 0;

    cart_bs_detect_if dl();

    cart_bs_detect dut (
        .clk(clk), .reset_n(reset_n), .dl(dl), .ext_bs(ext_bs), .sc_mode(sc_mode),
        .bs(bs), .sc(sc), .rom_size(rom_size), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // reference: count signature occurrences over the scanned bytes and apply the decision rules directly
    function automatic exp_t model(input int n, input logic [3:0] ext, input logic [1:0] mode);
        exp_t e;
        int m, e0, e7, ua, cv, fe, f3;
        logic [23:0] w;
        bit auto_sc;
        m = (n < MAX) ? n : MAX;
        e0 = 0; e7 = 0; ua = 0; cv = 0; fe = 0; f3 = 0;
        for (int i = 2; i < m; i++) begin
            w = {img[i-2], img[i-1], img[i]};
            if (w == 24'h8DE01F || w == 24'hADE9FF) e0++;
            if (w == 24'hADE2FF || w == 24'hADE5FF) e7++;
            if (w == 24'h8D4002) ua++;
            if (w == 24'h9DFFF3) cv++;
            if (w == 24'hD0C6C5) fe++;
            if (w[15:0] == 16'h853F) f3++;
        end
        if (ext != 0) e.bs = ext;
        else if (n == 10240) e.bs = 4'd7;
        else if (n > 4096 && f3 >= 2) e.bs = 4'd5;
        else if (n == 8192 && e0 >= 1) e.bs = 4'd4;
        else if (n == 16384 && e7 >= 1) e.bs = 4'd12;
        else if (n == 8192 && ua >= 1) e.bs = 4'd11;
        else if (n <= 4096 && cv >= 1) e.bs = 4'd9;
        else if (n == 8192 && fe >= 1) e.bs = 4'd3;
        else if (n == 8192) e.bs = 4'd1;
        else if (n == 12288) e.bs = 4'd8;
        else if (n == 16384) e.bs = 4'd2;
        else if (n == 32768) e.bs = 4'd6;
        else e.bs = 4'd0;
`ifdef CART_BS_SC_DETECT_EN
        auto_sc = (n >= 8192);
        for (int i = 0; i < m; i++)
            if ((i % 4096) < 128 && img[i] != img[0]) auto_sc = 0;
`else
        auto_sc = 0;
`endif
        e.sc = (mode == 2'd1) ? 1'b0 : (mode >= 2'd2) ? 1'b1 : auto_sc;
        e.size = 17'((n > 131071) ? 131071 : n);
        return e;
    endfunction

    task automatic make_img(input int n, input int val);
        img = new[n];
        foreach (img[i]) img[i] = (val < 0) ? 8'($urandom) : 8'(val);
    endtask

    task automatic put(input int at, input logic [23:0] p, input int len);
        for (int k = 0; k < len; k++) img[at + k] = p[8*(len-1-k) +: 8];
    endtask

    // one download of img; expectation is queued first, the monitor checks the result
    task automatic download(input logic [3:0] ext, input logic [1:0] mode, input bit coinc, input bit gaps, input bit pre);
        int n;
        int c;
        n = img.size();
        exp_q.push_back(model(n, ext, mode));
        @(negedge clk);
        ext_bs = 4'($urandom);
        sc_mode = 2'($urandom);
        dl.dl_active = 1'b1;
        if (pre) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                dl.dl_wr = 1'b1;
                dl.dl_addr = 25'(i);
                dl.dl_data = (i == 0) ? 8'h9D : (i == 1) ? 8'hFF : 8'hF3;
            end
            @(negedge clk);
            dl.dl_wr = 1'b0;
            dl.dl_active = 1'b0;
            @(negedge clk);
            dl.dl_active = 1'b1;
        end
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            dl.dl_wr = 1'b1;
            dl.dl_addr = 25'(i);
            dl.dl_data = img[i];
            if (i == n - 1) begin
                ext_bs = ext;
                sc_mode = mode;
                if (coinc) dl.dl_active = 1'b0;
            end
            @(negedge clk);
            dl.dl_wr = 1'b0;
            if (i == n / 2) chk("busy_scan", 32'(busy), 32'd1);
            if (gaps && i < n - 1 && $urandom_range(3, 0) == 0) @(negedge clk);
        end
        c = (coinc && n > 0) ? 1 : 0;
        if (!(coinc && n > 0)) begin
            ext_bs = ext;
            sc_mode = mode;
            dl.dl_active = 1'b0;
        end
        while (!valid && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk("valid_latency", 32'(c), 32'd2);
        chk("busy_done", 32'(busy), 32'd0);
    endtask

    // monitor: every rising edge of valid consumes one queued expectation
    initial begin
        logic vq;
        exp_t e;
        vq = 1'b0;
        forever begin
            @(negedge clk);
            if (valid && !vq) begin
                chk("pending_result", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("bs", 32'(bs), 32'(e.bs));
                    chk("sc", 32'(sc), 32'(e.sc));
                    chk("rom_size", 32'(rom_size), 32'(e.size));
                end
            end
            vq = valid;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [23:0] pats[8];
        pats = '{24'h8DE01F, 24'hADE9FF, 24'hADE2FF, 24'hADE5FF, 24'h8D4002, 24'h9DFFF3, 24'hD0C6C5, 24'h77853F};
        dl.dl_active = 1'b0;
        dl.dl_wr = 1'b0;
        dl.dl_addr = 25'd0;
        dl.dl_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_bs", 32'(bs), 32'd0);
        chk("rst_sc", 32'(sc), 32'd0);
        chk("rst_size", 32'(rom_size), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        make_img(8192, 0);
        put(16'h100, 24'h8DE01F, 3);
        download(4'd0, 2'd0, 1'b1, 1'b0, 1'b0);

        make_img(32768, 8'hEA);
        download(4'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        make_img(2048, 8'hEA);
        download(4'd2, 2'd1, 1'b0, 1'b0, 1'b0);

        make_img(10240, -1);
        put(16'h200, 24'h00853F, 2);
        put(16'h900, 24'h00853F, 2);
        download(4'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        make_img(8192, 0);
        put(16'h10, 24'h00853F, 2);
        put(16'h20, 24'h00853F, 2);
        put(16'h100, 24'h8DE01F, 3);
        img[4101] = 8'h01;
        download(4'd0, 2'd0, 1'b1, 1'b0, 1'b0);

        chk("idle_valid_before", 32'(valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            dl.dl_wr = 1'b1;
            dl.dl_addr = 25'(20000 + i);
            dl.dl_data = 8'h55;
            @(negedge clk);
        end
        dl.dl_wr = 1'b0;
        @(negedge clk);
        chk("idle_wr_size", 32'(rom_size), 32'd8192);
        chk("idle_wr_valid", 32'(valid), 32'd1);

        make_img(4096, -1);
        @(negedge clk);
        dl.dl_active = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3100; i++) begin
            if (i == 3000) begin
                dl.dl_wr = 1'b0;
                reset_n = 1'b0;
                #1;
                chk("midrst_bs", 32'(bs), 32'd0);
                chk("midrst_sc", 32'(sc), 32'd0);
                chk("midrst_size", 32'(rom_size), 32'd0);
                chk("midrst_valid", 32'(valid), 32'd0);
                chk("midrst_busy", 32'(busy), 32'd0);
                @(negedge clk);
                reset_n = 1'b1;
            end
            dl.dl_wr = 1'b1;
            dl.dl_addr = 25'(i);
            dl.dl_data = img[i];
            @(negedge clk);
            dl.dl_wr = 1'b0;
        end
        dl.dl_active = 1'b0;
        repeat (6) @(negedge clk);
        chk("postrst_valid", 32'(valid), 32'd0);
        chk("postrst_busy", 32'(busy), 32'd0);
        chk("postrst_size", 32'(rom_size), 32'd0);

        make_img(4096, -1);
        download(4'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        make_img(0, 0);
        download(4'd3, 2'd2, 1'b0, 1'b0, 1'b0);
        download(4'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        make_img(1024, 8'h11);
        download(4'd0, 2'd0, 1'b0, 1'b0, 1'b1);

        make_img(2048, -1);
        put(16'h33, 24'h9DFFF3, 3);
        download(4'd0, 2'd3, 1'b1, 1'b0, 1'b0);

        for (int t = 0; t < 5; t++) begin
            make_img($urandom_range(2047, 1), -1);
            for (int k = 0; k < 2; k++)
                if (img.size() >= 3) put($urandom_range(img.size() - 3, 0), pats[$urandom_range(7, 0)], 3);
            download(($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'd0, 2'($urandom), 1'($urandom), 1'b1, 1'b0);
        end

        c = 0;
        while (exp_q.size() != 0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
